// File: rtl/bob_pkg.sv
// bob_pkg: shared defaults and count-field widths for the branch-order buffer
package bob_pkg;
  localparam int BOB_DEPTH     = 48;
  localparam int BOB_ADDR_W    = 6;
  localparam int BOB_ALLOC_W   = 2;
  localparam int BOB_RETIRE_W  = 2;
  localparam int BOB_CNT_W     = BOB_ADDR_W + 1;
  localparam int BOB_NEW_CNT_W = $clog2(BOB_ALLOC_W + 1);
  localparam int BOB_RET_CNT_W = $clog2(BOB_RETIRE_W + 1);
endpackage

// File: rtl/bob_alloc_if.sv
// bob_alloc_if: allocate/retire handshake between front-end, retire logic and bob_alloc
interface bob_alloc_if import bob_pkg::*; #(
  parameter int ADDR_WIDTH = BOB_ADDR_W,
  parameter int ALLOC_W    = BOB_ALLOC_W,
  parameter int RETIRE_W   = BOB_RETIRE_W,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
);
  logic                          except;
  logic [$clog2(ALLOC_W+1)-1:0]  new_cnt;
  logic                          stall;
  logic [ADDR_WIDTH-1:0]         new_addr;
  logic                          doStall;
  logic [$clog2(RETIRE_W+1)-1:0] retire_avail;
  logic [$clog2(RETIRE_W+1)-1:0] ret_cnt;
  logic [ADDR_WIDTH-1:0]         retire_addr;
  logic [CNT_WIDTH-1:0]          used_cnt;
  logic                          err;
  modport master (
    output except, new_cnt, stall, ret_cnt,
    input  new_addr, doStall, retire_avail, retire_addr, used_cnt, err
  );
  modport slave (
    input  except, new_cnt, stall, ret_cnt,
    output new_addr, doStall, retire_avail, retire_addr, used_cnt, err
  );
endinterface

// File: rtl/bob_ptr_adv.sv
// bob_ptr_adv: combinational pointer advance (ptr + n) mod DEPTH for non-power-of-two depths
module bob_ptr_adv import bob_pkg::*; #(
  parameter int DEPTH      = BOB_DEPTH,
  parameter int ADDR_WIDTH = BOB_ADDR_W,
  parameter int N_WIDTH    = BOB_NEW_CNT_W
) (
  input  logic [ADDR_WIDTH-1:0] ptr,
  input  logic [N_WIDTH-1:0]    n,
  output logic [ADDR_WIDTH-1:0] nxt
);
  logic [ADDR_WIDTH:0] sum;
  assign sum = {1'b0, ptr} + (ADDR_WIDTH+1)'(n);
  assign nxt = sum >= (ADDR_WIDTH+1)'(DEPTH) ? ADDR_WIDTH'(sum - (ADDR_WIDTH+1)'(DEPTH)) : ADDR_WIDTH'(sum);
endmodule

// File: rtl/bob_alloc.sv
// bob_alloc: BOB head/tail pointer manager; BOB_ALLOC_CHK_EN enables sticky protocol checking on err
module bob_alloc import bob_pkg::*; #(
  parameter int DEPTH      = BOB_DEPTH,
  parameter int ADDR_WIDTH = BOB_ADDR_W,
  parameter int ALLOC_W    = BOB_ALLOC_W,
  parameter int RETIRE_W   = BOB_RETIRE_W,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input logic         clk,
  input logic         rst,
  bob_alloc_if.slave  bus
);
  localparam int NW = $clog2(ALLOC_W + 1);
  localparam int RW = $clog2(RETIRE_W + 1);
  logic [ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d, head_adv, tail_adv;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]         avail_q, avail_d, ret_n;
  logic [NW-1:0]         alloc_n;
  logic                  err_q, err_d, full;
  assign full = cnt_q > CNT_WIDTH'(DEPTH - ALLOC_W);
  // accepted alloc/retire amounts; except drops both, the checker suppresses illegal requests
  always_comb begin
`ifdef BOB_ALLOC_CHK_EN
    alloc_n = (!bus.stall && !full && !bus.except && bus.new_cnt <= NW'(ALLOC_W)) ? bus.new_cnt : '0;
    ret_n   = (!bus.except && bus.ret_cnt <= avail_q) ? bus.ret_cnt : '0;
    err_d   = err_q | (bus.ret_cnt > avail_q) | (bus.new_cnt > NW'(ALLOC_W));
`else
    alloc_n = (!bus.stall && !full && !bus.except) ? bus.new_cnt : '0;
    ret_n   = !bus.except ? bus.ret_cnt : '0;
    err_d   = 1'b0;
`endif
  end
  bob_ptr_adv #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .N_WIDTH(NW)) u_head (.ptr(head_q), .n(alloc_n), .nxt(head_adv));
  bob_ptr_adv #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .N_WIDTH(RW)) u_tail (.ptr(tail_q), .n(ret_n), .nxt(tail_adv));
  // next pointers and occupancy; except snaps the tail onto the unchanged head
  always_comb begin
    head_d  = head_adv;
    tail_d  = bus.except ? head_q : tail_adv;
    cnt_d   = bus.except ? '0 : cnt_q + CNT_WIDTH'(alloc_n) - CNT_WIDTH'(ret_n);
    avail_d = cnt_d > CNT_WIDTH'(RETIRE_W) ? RW'(RETIRE_W) : RW'(cnt_d);
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      avail_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      avail_q <= avail_d;
      err_q   <= err_d;
    end
  end
  assign bus.new_addr     = head_q;
  assign bus.retire_addr  = tail_q;
  assign bus.used_cnt     = cnt_q;
  assign bus.retire_avail = avail_q;
  assign bus.doStall      = full;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_bob_alloc.sv
// tb_bob_alloc: randomized and directed checks of bob_alloc against an entry-queue model
module tb_bob_alloc;
  localparam int DEPTH = 48, AW = 6, ALLOC_W = 2, RETIRE_W = 2;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0;
  int head = 0, tail = 0;
  int q[$];
  bob_alloc_if #(.ADDR_WIDTH(AW), .ALLOC_W(ALLOC_W), .RETIRE_W(RETIRE_W)) b();
  bob_alloc #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .ALLOC_W(ALLOC_W), .RETIRE_W(RETIRE_W)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int avail_m();
    return q.size() < RETIRE_W ? q.size() : RETIRE_W;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ":new_addr"}, b.new_addr, head);
    chk({tag, ":retire_addr"}, b.retire_addr, tail);
    chk({tag, ":used_cnt"}, b.used_cnt, q.size());
    chk({tag, ":retire_avail"}, b.retire_avail, avail_m());
    chk({tag, ":doStall"}, b.doStall, int'(q.size() > DEPTH - ALLOC_W));
    chk({tag, ":err"}, b.err, 0);
  endtask

  task automatic cycle(input string tag, input bit e, input int nc, input bit st, input int rc);
    bit ds;
    b.except = e; b.new_cnt = 2'(nc); b.stall = st; b.ret_cnt = 2'(rc);
    ds = q.size() > DEPTH - ALLOC_W;
    @(posedge clk); #1;
    if (e) begin
      q.delete();
      tail = head;
    end else begin
      if (nc != 0 && !st && !ds) repeat (nc) begin q.push_back(head); head = (head + 1) % DEPTH; end
      repeat (rc) begin void'(q.pop_front()); tail = (tail + 1) % DEPTH; end
    end
    b.except = 0; b.new_cnt = 0; b.stall = 0; b.ret_cnt = 0;
    chk_all(tag);
  endtask

  task automatic model_reset();
    q.delete(); head = 0; tail = 0;
  endtask

  initial begin
    b.except = 0; b.new_cnt = 0; b.stall = 0; b.ret_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_all("reset");
    for (int i = 0; i < 400; i++)
      cycle("rand", $urandom_range(0, 39) == 0, $urandom_range(0, ALLOC_W), $urandom_range(0, 4) == 0, $urandom_range(0, avail_m()));
    #3 rst = 1;
    #1;
    model_reset();
    chk_all("async_reset");
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 23; i++) cycle("fill", 0, 2, 0, 0);
    chk("fill46:used_cnt", b.used_cnt, 46);
    chk("fill46:doStall", b.doStall, 0);
    cycle("fill", 0, 2, 0, 0);
    chk("full:used_cnt", b.used_cnt, 48);
    chk("full:doStall", b.doStall, 1);
    chk("full:new_addr", b.new_addr, 0);
    cycle("full_req", 0, 2, 0, 0);
    chk("full_req:used_cnt", b.used_cnt, 48);
    rst = 1; #1 model_reset(); @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 23; i++) cycle("prewrap", 0, 2, 0, 0);
    cycle("prewrap", 0, 1, 0, 0);
    cycle("prewrap_exc", 1, 0, 0, 0);
    chk("prewrap:new_addr", b.new_addr, 47);
    chk("prewrap:retire_addr", b.retire_addr, 47);
    cycle("wrap_alloc", 0, 2, 0, 0);
    chk("wrap:new_addr", b.new_addr, 1);
    cycle("wrap_ret", 0, 0, 0, 2);
    chk("wrap:retire_addr", b.retire_addr, 1);
    for (int i = 0; i < 5; i++) cycle("sim_pre", 0, 2, 0, 0);
    chk("sim_pre:used_cnt", b.used_cnt, 10);
    cycle("sim", 0, 2, 0, 2);
    chk("sim:used_cnt", b.used_cnt, 10);
    chk("sim:new_addr", b.new_addr, 13);
    chk("sim:retire_addr", b.retire_addr, 3);
    chk("sim:retire_avail", b.retire_avail, 2);
    cycle("exc_pre", 0, 2, 0, 2);
    cycle("exc_pre", 0, 2, 0, 0);
    cycle("exc_pre", 0, 2, 0, 0);
    cycle("exc_pre", 0, 1, 0, 0);
    chk("exc_pre:new_addr", b.new_addr, 20);
    chk("exc_pre:retire_addr", b.retire_addr, 5);
    chk("exc_pre:used_cnt", b.used_cnt, 15);
    cycle("exc", 1, 2, 0, 0);
    chk("exc:retire_addr", b.retire_addr, 20);
    chk("exc:new_addr", b.new_addr, 20);
    chk("exc:used_cnt", b.used_cnt, 0);
    chk("exc:retire_avail", b.retire_avail, 0);
    chk("exc:doStall", b.doStall, 0);
    cycle("chk_pre", 0, 1, 0, 0);
    chk("chk_pre:retire_avail", b.retire_avail, 1);
    b.ret_cnt = 2;
    @(posedge clk); #1 b.ret_cnt = 0;
`ifdef BOB_ALLOC_CHK_EN
    chk("checker:err", b.err, 1);
    chk("checker:retire_addr", b.retire_addr, 20);
    chk("checker:used_cnt", b.used_cnt, 1);
    @(posedge clk); #1;
    chk("checker:err_sticky", b.err, 1);
`else
    chk("checker:err", b.err, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
